// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline stage with a blocking memory handshake, access timeout and branch resolution.
// Ports:
//    clock, reset (async, active-low)
//    in_valid, aluResult, writeData, writeReg, regWrite, memRead, memWrite,
//    memToReg, branch, zero, branchTarget, flush   -- bundle from EX
//    stall                                          -- hold upstream while a memory access is outstanding
//    mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata -- memory handshake
//    out_valid, out_result, out_writeReg, out_regWrite         -- retired bundle to MEM/WB
//    pcSrc, pcTarget                                -- branch redirect to the PC
//    bus_err                                        -- one-cycle error pulse on timeout or misaligned trap
// Build option: define MISALIGN_TRAP_EN to trap memory ops with aluResult[1:0]!=0 instead of aligning them.
module ex_mem_stage #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] aluResult,
   input  logic [31:0] writeData,
   input  logic [4:0]  writeReg,
   input  logic        regWrite,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic        memToReg,
   input  logic        branch,
   input  logic        zero,
   input  logic [31:0] branchTarget,
   input  logic        flush,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [31:0] out_result,
   output logic [4:0]  out_writeReg,
   output logic        out_regWrite,
   output logic        pcSrc,
   output logic [31:0] pcTarget,
   output logic        bus_err
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, ERR = 2'd2;
   logic [1:0]  state;
   logic [7:0]  cnt;
   logic [31:0] alu_q, tgt_q;
   logic [4:0]  wreg_q;
   logic        rw_q, m2r_q, take_q;
   logic        mem_op, misalign, take;
   assign stall  = state == REQ;
   assign mem_op = memRead | memWrite;
   assign take   = branch & zero;
`ifdef MISALIGN_TRAP_EN
   assign misalign = mem_op && aluResult[1:0] != 2'b00;
`else
   assign misalign = 1'b0;
`endif
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         alu_q        <= '0;
         tgt_q        <= '0;
         wreg_q       <= '0;
         rw_q         <= 1'b0;
         m2r_q        <= 1'b0;
         take_q       <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_writeReg <= '0;
         out_regWrite <= 1'b0;
         pcSrc        <= 1'b0;
         pcTarget     <= '0;
         bus_err      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         pcSrc     <= 1'b0;
         bus_err   <= 1'b0;
         case (state)
            IDLE: if (in_valid && !flush) begin
               alu_q  <= aluResult;
               tgt_q  <= branchTarget;
               wreg_q <= writeReg;
               rw_q   <= regWrite;
               m2r_q  <= memToReg;
               take_q <= take;
               if (misalign) begin
                  state        <= ERR;
                  bus_err      <= 1'b1;
                  out_regWrite <= 1'b0;
               end else if (mem_op) begin
                  // memWrite wins when both memRead and memWrite are set
                  state     <= REQ;
                  cnt       <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= memWrite;
                  mem_addr  <= {aluResult[31:2], 2'b00};
                  mem_wdata <= writeData;
               end else begin
                  out_valid    <= 1'b1;
                  out_result   <= aluResult;
                  out_writeReg <= writeReg;
                  out_regWrite <= regWrite;
                  pcSrc        <= take;
                  if (take) pcTarget <= branchTarget;
               end
            end
            REQ: if (mem_ack) begin
               state        <= IDLE;
               mem_req      <= 1'b0;
               mem_we       <= 1'b0;
               out_valid    <= 1'b1;
               out_result   <= m2r_q ? mem_rdata : alu_q;
               out_writeReg <= wreg_q;
               out_regWrite <= rw_q;
               pcSrc        <= take_q;
               if (take_q) pcTarget <= tgt_q;
            end else begin
               cnt <= cnt + 8'd1;
               // the cycle that brings the counter to TIMEOUT_CYCLES ends the access
               if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  state        <= ERR;
                  mem_req      <= 1'b0;
                  mem_we       <= 1'b0;
                  bus_err      <= 1'b1;
                  out_regWrite <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage built with TIMEOUT_CYCLES=4.
module tb_ex_mem_stage;
   logic        clock = 1'b0, reset = 1'b0;
   logic        in_valid = 0, regWrite = 0, memRead = 0, memWrite = 0, memToReg = 0;
   logic        branch = 0, zero = 0, flush = 0, mem_ack = 0;
   logic [31:0] aluResult = 0, writeData = 0, branchTarget = 0, mem_rdata = 0;
   logic [4:0]  writeReg = 0;
   logic        stall, mem_req, mem_we, out_valid, out_regWrite, pcSrc, bus_err;
   logic [31:0] mem_addr, mem_wdata, out_result, pcTarget;
   logic [4:0]  out_writeReg;
   int          n_checks = 0, n_fail = 0;
   int          mreq_cnt, berr_cnt, ov_cnt;

   ex_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .aluResult(aluResult),
      .writeData(writeData), .writeReg(writeReg), .regWrite(regWrite), .memRead(memRead),
      .memWrite(memWrite), .memToReg(memToReg), .branch(branch), .zero(zero),
      .branchTarget(branchTarget), .flush(flush), .stall(stall), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_result(out_result),
      .out_writeReg(out_writeReg), .out_regWrite(out_regWrite), .pcSrc(pcSrc),
      .pcTarget(pcTarget), .bus_err(bus_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic bundle(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                         input logic rd, input logic we, input logic m2r);
      in_valid = 1; aluResult = alu; writeReg = wr; regWrite = rw;
      memRead = rd; memWrite = we; memToReg = m2r; branch = 0; zero = 0;
   endtask

   initial begin
      #3;
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_pcTarget", pcTarget, 0);
      chk("rst_bus_err", bus_err, 0);
      #9 reset = 1;
      // ADD retires one cycle after capture at the first edge after reset release
      bundle(32'h10, 5, 1, 0, 0, 0);
      step();
      chk("add_valid", out_valid, 1);
      chk("add_result", out_result, 32'h10);
      chk("add_wreg", out_writeReg, 5);
      chk("add_rw", out_regWrite, 1);
      chk("add_stall", stall, 0);
      in_valid = 0;
      step();
      chk("add_pulse", out_valid, 0);
      chk("add_hold", out_result, 32'h10);
      // back-to-back non-memory stream
      bundle(32'h11, 6, 1, 0, 0, 0);
      step();
      chk("b2b1_valid", out_valid, 1);
      chk("b2b1_result", out_result, 32'h11);
      bundle(32'h12, 7, 0, 0, 0, 0);
      step();
      chk("b2b2_valid", out_valid, 1);
      chk("b2b2_result", out_result, 32'h12);
      chk("b2b2_rw", out_regWrite, 0);
      in_valid = 0;
      // stray ack while idle is ignored
      mem_ack = 1; mem_rdata = 32'h1234;
      step();
      mem_ack = 0;
      chk("idle_ack_valid", out_valid, 0);
      chk("idle_ack_req", mem_req, 0);
      // LW acked in the third REQ cycle; a bundle offered during stall waits
      bundle(32'h20, 8, 1, 1, 0, 1);
      step();
      bundle(32'h99, 10, 1, 0, 0, 0);
      chk("lw_req", mem_req, 1);
      chk("lw_we", mem_we, 0);
      chk("lw_addr", mem_addr, 32'h20);
      chk("lw_stall1", stall, 1);
      step();
      chk("lw_stall2", stall, 1);
      chk("lw_no_valid", out_valid, 0);
      step();
      chk("lw_stall3", stall, 1);
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 0;
      chk("lw_valid", out_valid, 1);
      chk("lw_result", out_result, 32'hDEAD_BEEF);
      chk("lw_rw", out_regWrite, 1);
      chk("lw_wreg", out_writeReg, 8);
      chk("lw_stall_end", stall, 0);
      chk("lw_req_end", mem_req, 0);
      step();
      in_valid = 0;
      chk("held_valid", out_valid, 1);
      chk("held_result", out_result, 32'h99);
      chk("held_wreg", out_writeReg, 10);
      // read+write treated as write, acked in the first REQ cycle, address aligned
      bundle(32'h33, 11, 0, 1, 1, 0);
      writeData = 32'hCAFE;
      step();
      in_valid = 0;
      chk("sw_req", mem_req, 1);
      chk("sw_we", mem_we, 1);
      chk("sw_addr", mem_addr, 32'h30);
      chk("sw_wdata", mem_wdata, 32'hCAFE);
      mem_ack = 1; mem_rdata = 32'h55;
      step();
      mem_ack = 0;
      chk("sw_valid", out_valid, 1);
      chk("sw_result", out_result, 32'h33);
      chk("sw_req_end", mem_req, 0);
      // SW never acked: four REQ cycles, one bus_err, no retire
      bundle(32'h40, 12, 1, 0, 1, 0);
      writeData = 32'h1;
      step();
      in_valid = 0;
      mreq_cnt = 0; berr_cnt = 0; ov_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         mreq_cnt += int'(mem_req);
         berr_cnt += int'(bus_err);
         ov_cnt   += int'(out_valid);
         step();
      end
      chk("to_req_cycles", mreq_cnt, 4);
      chk("to_bus_err", berr_cnt, 1);
      chk("to_no_valid", ov_cnt, 0);
      chk("to_rw", out_regWrite, 0);
      chk("to_idle", stall, 0);
      // branch taken then not taken
      bundle(32'h0, 0, 0, 0, 0, 0);
      branch = 1; zero = 1; branchTarget = 32'h40;
      step();
      chk("beq_valid", out_valid, 1);
      chk("beq_pcsrc", pcSrc, 1);
      chk("beq_target", pcTarget, 32'h40);
      zero = 0; branchTarget = 32'h80;
      step();
      in_valid = 0; branch = 0;
      chk("bne_valid", out_valid, 1);
      chk("bne_pcsrc", pcSrc, 0);
      chk("bne_target", pcTarget, 32'h40);
      // flushed memory op does nothing
      bundle(32'h50, 13, 1, 1, 0, 1);
      flush = 1;
      step();
      flush = 0; in_valid = 0;
      chk("flush_valid", out_valid, 0);
      chk("flush_req", mem_req, 0);
      chk("flush_stall", stall, 0);
      step();
      chk("flush_req2", mem_req, 0);
      // reset in the second REQ cycle drops mem_req asynchronously
      bundle(32'h60, 14, 1, 1, 0, 1);
      step();
      in_valid = 0;
      step();
      chk("rr_req", mem_req, 1);
      #2 reset = 0;
      #1;
      chk("rr_req_drop", mem_req, 0);
      chk("rr_stall", stall, 0);
      chk("rr_pctarget", pcTarget, 0);
      #2 reset = 1;
      bundle(32'h70, 9, 1, 0, 0, 0);
      step();
      in_valid = 0;
      chk("rr_add_valid", out_valid, 1);
      chk("rr_add_result", out_result, 32'h70);
      // misaligned load
      bundle(32'h22, 15, 1, 1, 0, 1);
      step();
      in_valid = 0;
`ifdef MISALIGN_TRAP_EN
      chk("mis_req", mem_req, 0);
      chk("mis_bus_err", bus_err, 1);
      step();
      chk("mis_valid", out_valid, 0);
      chk("mis_err_end", bus_err, 0);
`else
      chk("mis_req", mem_req, 1);
      chk("mis_addr", mem_addr, 32'h20);
      mem_ack = 1; mem_rdata = 32'h77;
      step();
      mem_ack = 0;
      chk("mis_valid", out_valid, 1);
      chk("mis_result", out_result, 32'h77);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
